// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core controller.
// phase_t enumerates every sequencer phase; encodings are fixed and visible on the phase port.
package cpu_pkg;

    typedef enum logic [4:0] {
        STARTUP   = 5'd0,
        BOOT_REQ  = 5'd1,
        BOOT_SIZE = 5'd2,
        BOOT_DATA = 5'd3,
        BOOT_ACK  = 5'd4,
        INIT      = 5'd5,
        IF        = 5'd6,
        IF_ID     = 5'd7,
        ID        = 5'd8,
        ID_EX     = 5'd9,
        EX        = 5'd10,
        EX_MEM    = 5'd11,
        MEM       = 5'd12,
        MEM_WB    = 5'd13,
        WB        = 5'd14,
        WB_IF     = 5'd15,
        HALT      = 5'd16
    } phase_t;

    // Run-loop phases are the only ones that honour stall.
    function automatic logic is_run_phase(input phase_t p);
        return (p >= IF) && (p <= WB_IF);
    endfunction

endpackage

// File: rtl/phase_wait_timer.sv
// Loadable down-counter that saturates at zero; shared by the EX and MEM wait states.
// load wins over hold; zero reflects the registered count.
module phase_wait_timer #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              hold,
    output logic              zero
);

    logic [WAIT_W-1:0] count_reg;
    logic [WAIT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (!hold && (count_reg != '0)) begin
            count_next = count_reg - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Phase sequencer for the non-pipelined core: program-load handshake, then IF..WB_IF per
// instruction with one-cycle write strobes, EX/MEM wait states, stall, halt and instret.
module stage_sequencer
    import cpu_pkg::*;
#(
    parameter int EX_WAIT_CYCLES  = 0,
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int WAIT_W          = 4,
    parameter int BOOT_ENABLE     = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_busy,
    input  logic             halt,
    input  logic             size_fetch_done,
    input  logic             data_fetch_done,
    output logic             tx_0x99,
    output logic             size_we,
    output logic             prog_we,
    output logic             tx_0xAA,
    output logic             stdin_we,
    output logic             wb_if_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             ram_we,
    output logic             reg_we,
    output logic             pipe_rst,
    output logic [4:0]       phase,
    output logic [CNT_W-1:0] instret
);

    localparam logic [WAIT_W-1:0] EX_LOAD  = WAIT_W'(EX_WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(MEM_WAIT_CYCLES);

    phase_t            phase_reg;
    phase_t            phase_next;
    logic [CNT_W-1:0]  instret_reg;
    logic [CNT_W-1:0]  instret_next;
    logic              stall_eff;
    logic              timer_load;
    logic [WAIT_W-1:0] timer_val;
    logic              timer_hold;
    logic              timer_zero;

    assign stall_eff = stall && is_run_phase(phase_reg);

    // The counter only moves while sitting unstalled in EX or MEM.
    assign timer_hold = stall_eff || !((phase_reg == EX) || (phase_reg == MEM));

    phase_wait_timer #(
        .WAIT_W (WAIT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .hold     (timer_hold),
        .zero     (timer_zero)
    );

    always_comb begin
        phase_next   = phase_reg;
        instret_next = instret_reg;
        timer_load   = 1'b0;
        timer_val    = EX_LOAD;
        case (phase_reg)
            STARTUP:   phase_next = (BOOT_ENABLE != 0) ? BOOT_REQ : INIT;
            BOOT_REQ:  phase_next = BOOT_SIZE;
            BOOT_SIZE: if (size_fetch_done) phase_next = BOOT_DATA;
            BOOT_DATA: if (data_fetch_done) phase_next = BOOT_ACK;
            BOOT_ACK:  phase_next = INIT;
            INIT:      phase_next = IF;
            IF:        if (!stall_eff) phase_next = IF_ID;
            IF_ID:     if (!stall_eff) phase_next = ID;
            ID:        if (!stall_eff) phase_next = ID_EX;
            ID_EX: begin
                if (!stall_eff) begin
                    phase_next = EX;
                    timer_load = 1'b1;
                    timer_val  = EX_LOAD;
                end
            end
            EX:        if (!stall_eff && timer_zero && !ex_busy) phase_next = EX_MEM;
            EX_MEM: begin
                if (!stall_eff) begin
                    phase_next = MEM;
                    timer_load = 1'b1;
                    timer_val  = MEM_LOAD;
                end
            end
            MEM:       if (!stall_eff && timer_zero) phase_next = MEM_WB;
            MEM_WB:    if (!stall_eff) phase_next = WB;
            WB: begin
                if (!stall_eff) begin
                    if (halt) begin
                        phase_next   = HALT;
                        instret_next = instret_reg + CNT_W'(1);
                    end else begin
                        phase_next = WB_IF;
                    end
                end
            end
            WB_IF: begin
                if (!stall_eff) begin
                    phase_next   = IF;
                    instret_next = instret_reg + CNT_W'(1);
                end
            end
            HALT:      phase_next = HALT;
            default:   phase_next = STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg   <= STARTUP;
            instret_reg <= '0;
        end else begin
            phase_reg   <= phase_next;
            instret_reg <= instret_next;
        end
    end

    assign tx_0x99  = (phase_reg == BOOT_REQ);
    assign size_we  = (phase_reg == BOOT_SIZE);
    assign prog_we  = (phase_reg == BOOT_DATA);
    assign tx_0xAA  = (phase_reg == BOOT_ACK);
    assign stdin_we = (phase_reg >= BOOT_ACK) && (phase_reg != HALT);
    assign pipe_rst = (phase_reg == STARTUP) || (phase_reg == INIT);

    // Run-loop strobes are the only outputs with a combinational input path (stall).
    assign if_id_we  = (phase_reg == IF_ID)  && !stall;
    assign id_ex_we  = (phase_reg == ID_EX)  && !stall;
    assign ex_mem_we = (phase_reg == EX_MEM) && !stall;
    assign mem_wb_we = (phase_reg == MEM_WB) && !stall;
    assign ram_we    = (phase_reg == MEM) && timer_zero && !stall;
    assign reg_we    = (phase_reg == WB)     && !stall;
    assign wb_if_we  = (phase_reg == WB_IF)  && !stall;

    assign phase   = phase_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a vector table through boot and one instruction,
// then hand-written sequences for spacing, halt, ex_busy and asynchronous reset.
module tb_stage_sequencer;

    localparam logic [4:0] P_STARTUP = 5'd0,  P_BOOT_REQ = 5'd1, P_BOOT_SIZE = 5'd2,
                           P_BOOT_DATA = 5'd3, P_BOOT_ACK = 5'd4, P_INIT = 5'd5,
                           P_IF = 5'd6, P_IF_ID = 5'd7, P_ID = 5'd8, P_ID_EX = 5'd9,
                           P_EX = 5'd10, P_EX_MEM = 5'd11, P_MEM = 5'd12, P_MEM_WB = 5'd13,
                           P_WB = 5'd14, P_WB_IF = 5'd15, P_HALT = 5'd16;

    localparam logic [12:0] S_TX99 = 13'h1000, S_SIZE = 13'h0800, S_PROG = 13'h0400,
                            S_TXAA = 13'h0200, S_STD = 13'h0100, S_WBIF = 13'h0080,
                            S_IFID = 13'h0040, S_IDEX = 13'h0020, S_EXMEM = 13'h0010,
                            S_MEMWB = 13'h0008, S_RAM = 13'h0004, S_REG = 13'h0002,
                            S_PRST = 13'h0001, S_NONE = 13'h0000;

    typedef struct {
        logic       stall;
        logic       halt;
        logic       sfd;
        logic       dfd;
        logic [4:0] ph;
        logic [12:0] st;
    } vec_t;

    typedef struct {
        logic [4:0]  ph;
        logic [12:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic halt = 1'b0;
    logic sfd = 1'b0;
    logic dfd = 1'b0;
    logic ex_busy0 = 1'b0;
    logic ex_busy1 = 1'b0;

    wire [12:0] st0, st1;
    wire [4:0]  ph0, ph1;
    wire [31:0] ir0, ir1;

    int n_chk = 0;
    int n_fail = 0;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   reg_exp_q[$];

    always #5 clk = ~clk;

    stage_sequencer dut0 (
        .clk(clk), .reset(reset), .stall(stall), .ex_busy(ex_busy0), .halt(halt),
        .size_fetch_done(sfd), .data_fetch_done(dfd),
        .tx_0x99(st0[12]), .size_we(st0[11]), .prog_we(st0[10]), .tx_0xAA(st0[9]),
        .stdin_we(st0[8]), .wb_if_we(st0[7]), .if_id_we(st0[6]), .id_ex_we(st0[5]),
        .ex_mem_we(st0[4]), .mem_wb_we(st0[3]), .ram_we(st0[2]), .reg_we(st0[1]),
        .pipe_rst(st0[0]), .phase(ph0), .instret(ir0)
    );

    stage_sequencer #(.EX_WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .ex_busy(ex_busy1), .halt(halt),
        .size_fetch_done(sfd), .data_fetch_done(dfd),
        .tx_0x99(st1[12]), .size_we(st1[11]), .prog_we(st1[10]), .tx_0xAA(st1[9]),
        .stdin_we(st1[8]), .wb_if_we(st1[7]), .if_id_we(st1[6]), .id_ex_we(st1[5]),
        .ex_mem_we(st1[4]), .mem_wb_we(st1[3]), .ram_we(st1[2]), .reg_we(st1[1]),
        .pipe_rst(st1[0]), .phase(ph1), .instret(ir1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic addv(input logic s, input logic h, input logic sf, input logic df,
                        input logic [4:0] ph, input logic [12:0] st);
        vec_t v;
        v.stall = s; v.halt = h; v.sfd = sf; v.dfd = df; v.ph = ph; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tx99_cnt, txaa_cnt, size_cnt;
        int last_ifid, last_idex, off, ex_cycles, exmem_cnt, entry;
        bit found, entered;
        exp_t e;

        // stall halt sfd dfd | phase | strobes
        addv(0,0,0,0, P_STARTUP,   S_PRST);
        addv(0,0,0,0, P_BOOT_REQ,  S_TX99);
        addv(0,0,0,1, P_BOOT_SIZE, S_SIZE);
        addv(1,0,0,0, P_BOOT_SIZE, S_SIZE);
        addv(0,0,0,0, P_BOOT_SIZE, S_SIZE);
        addv(1,0,1,0, P_BOOT_SIZE, S_SIZE);
        addv(0,0,1,0, P_BOOT_DATA, S_PROG);
        addv(0,0,0,1, P_BOOT_DATA, S_PROG);
        addv(0,0,0,0, P_BOOT_ACK,  S_TXAA | S_STD);
        addv(1,0,0,0, P_INIT,      S_PRST | S_STD);
        addv(1,0,0,0, P_IF,        S_STD);
        addv(0,0,0,0, P_IF,        S_STD);
        addv(1,0,0,0, P_IF_ID,     S_STD);
        addv(0,0,0,0, P_IF_ID,     S_IFID | S_STD);
        addv(0,0,0,0, P_ID,        S_STD);
        addv(0,0,0,0, P_ID_EX,     S_IDEX | S_STD);
        addv(0,0,0,0, P_EX,        S_STD);
        addv(1,0,0,0, P_EX_MEM,    S_STD);
        addv(0,0,0,0, P_EX_MEM,    S_EXMEM | S_STD);
        addv(0,1,0,0, P_MEM,       S_STD);
        addv(0,0,0,0, P_MEM,       S_STD);
        addv(1,0,0,0, P_MEM,       S_STD);
        addv(1,0,0,0, P_MEM,       S_STD);
        addv(0,0,0,0, P_MEM,       S_RAM | S_STD);
        addv(0,0,0,0, P_MEM_WB,    S_MEMWB | S_STD);
        addv(1,0,0,0, P_WB,        S_STD);
        addv(0,0,0,0, P_WB,        S_REG | S_STD);
        addv(0,0,0,0, P_WB_IF,     S_WBIF | S_STD);
        addv(0,0,0,0, P_IF,        S_STD);

        // Vector table: boot handshake, stall corners, one full instruction
        tx99_cnt = 0; txaa_cnt = 0; size_cnt = 0;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            stall = tbl[i].stall; halt = tbl[i].halt; sfd = tbl[i].sfd; dfd = tbl[i].dfd;
            e.ph = tbl[i].ph; e.st = tbl[i].st;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("tbl[%0d].phase", i), 32'(ph0), 32'(e.ph));
            chk($sformatf("tbl[%0d].strobes", i), 32'(st0), 32'(e.st));
            $display("vec %0d: stall=%0b phase=%0d strobes=%h", i, stall, ph0, st0);
            if (st0[12]) tx99_cnt++;
            if (st0[9])  txaa_cnt++;
            if (st0[11]) size_cnt++;
            tick();
        end
        stall = 1'b0; halt = 1'b0;
        chk("boot_tx99_pulses", tx99_cnt, 1);
        chk("boot_txaa_pulses", txaa_cnt, 1);
        chk("boot_size_we_cycles", size_cnt, 4);
        chk("tbl_instret", ir0, 1);

        // Fast boot, then three unstalled instructions
        sfd = 1'b1; dfd = 1'b1;
        do_reset();
        last_ifid = -100; last_idex = -100;
        reg_exp_q = '{10, 22, 34};
        for (int cyc = 0; cyc <= 42; cyc++) begin
            @(negedge clk);
            off = cyc - 6;
            if (cyc == 0) begin
                chk("reset_strobes", 32'(st0), 32'(S_PRST));
                chk("reset_instret", ir0, 0);
            end
            if (cyc <= 6) chk($sformatf("fastboot_phase_c%0d", cyc), 32'(ph0), cyc);
            if (st0[6]) last_ifid = off;
            if (st0[5]) last_idex = off;
            if (st0[2]) begin
                chk("if_id_to_ram_we", off - last_ifid, 7);
                chk("id_ex_to_ram_we", off - last_idex, 5);
            end
            if (st0[1]) begin
                if (reg_exp_q.size() == 0) chk("reg_we_unexpected", off, 0);
                else chk("reg_we_time", off, reg_exp_q.pop_front());
                $display("reg_we pulse at offset %0d, instret=%0d", off, ir0);
            end
            if (off == 35) chk("instret_before_3rd", ir0, 2);
            if (off == 36) begin
                chk("instret_after_3", ir0, 3);
                chk("phase_after_3", 32'(ph0), 32'(P_IF));
            end
            tick();
        end
        chk("reg_we_pulses_missing", reg_exp_q.size(), 0);

        // Halt in WB of the fourth instruction
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (ph0 == P_WB) begin
                found = 1;
                halt = 1'b1;
            end
            @(negedge clk);
            if (found) chk("halt_wb_reg_we", 32'(st0[1]), 1);
            tick();
        end
        halt = 1'b0;
        chk("halt_wb_reached", 32'(found), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_phase", 32'(ph0), 32'(P_HALT));
            chk("halt_strobes", 32'(st0), 32'(S_NONE));
            chk("halt_instret", ir0, 4);
            tick();
        end
        $display("halt: phase=%0d instret=%0d", ph0, ir0);

        // ex_busy for 5 cycles from EX entry with one EX wait cycle
        sfd = 1'b1; dfd = 1'b1;
        do_reset();
        entered = 0; entry = 0; ex_cycles = 0; exmem_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            if (!entered && ph1 == P_EX) begin
                entered = 1;
                entry = c;
            end
            ex_busy1 = entered && ((c - entry) < 5);
            @(negedge clk);
            if (ph1 == P_EX) ex_cycles++;
            if (st1[4]) exmem_cnt++;
            tick();
        end
        ex_busy1 = 1'b0;
        chk("ex_busy_ex_cycles", ex_cycles, 6);
        chk("ex_busy_ex_mem_we", exmem_cnt, 1);
        $display("ex_busy: EX cycles=%0d ex_mem_we pulses=%0d", ex_cycles, exmem_cnt);

        // Asynchronous reset in BOOT_DATA
        sfd = 1'b1; dfd = 1'b0;
        do_reset();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (ph0 == P_BOOT_DATA) found = 1;
            else tick();
        end
        chk("rst_boot_found", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_boot_phase", 32'(ph0), 32'(P_STARTUP));
        chk("rst_boot_strobes", 32'(st0), 32'(S_PRST));
        chk("rst_boot_instret", ir0, 0);
        $display("reset in BOOT_DATA: phase=%0d strobes=%h", ph0, st0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Asynchronous reset in MEM of the second instruction
        sfd = 1'b1; dfd = 1'b1;
        do_reset();
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (ph0 == P_MEM && ir0 == 32'd1) found = 1;
            else tick();
        end
        chk("rst_mem_found", 32'(found), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mem_phase", 32'(ph0), 32'(P_STARTUP));
        chk("rst_mem_strobes", 32'(st0), 32'(S_PRST));
        chk("rst_mem_instret", ir0, 0);
        $display("reset in MEM: phase=%0d instret=%0d", ph0, ir0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
